score_event_scheduler: RTL and testbench

Serialises scoring events from the monster, boss and asteroid logic into one paced stream of add amounts for the score digit chain. Each event type has its own pending counter. A round-robin arbiter grants one event at a time. The granted event's value is `weight * stage_num`, issued in chunks of at most `MAX_ADD`, with idle gaps between chunks so digit carries can ripple. The block sits between the game objects and `score`, and drives the score's add input instead of the raw died/exploded pulses.

---
 rtl/score_event_if.sv | 34 +++
 rtl/score_event_scheduler.sv | 156 +++++++++++++++
 tb/tb_score_event_scheduler.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/score_event_if.sv
// Scoring-event bundle between the game objects and the score scheduler.
// The master side raises events; the slave side returns paced add amounts.
interface score_event_if;
   logic       monster_died_pulse;
   logic       boss_died_pulse;
   logic       asteroid_exploded_pulse;
   logic [2:0] stage_num;
   logic       game_over;
   logic [2:0] add_amount;
   logic       busy;
   logic       overflow;

   modport master (
      output monster_died_pulse,
      output boss_died_pulse,
      output asteroid_exploded_pulse,
      output stage_num,
      output game_over,
      input  add_amount,
      input  busy,
      input  overflow
   );

   modport slave (
      input  monster_died_pulse,
      input  boss_died_pulse,
      input  asteroid_exploded_pulse,
      input  stage_num,
      input  game_over,
      output add_amount,
      output busy,
      output overflow
   );
endinterface

// File: rtl/score_event_scheduler.sv
// Round-robin serialiser of scoring events into paced add-amount chunks
// so the score digit chain has idle cycles to ripple its carries.
module score_event_scheduler #(
   parameter int unsigned MONSTER_WEIGHT  = 1,
   parameter int unsigned BOSS_WEIGHT     = 5,
   parameter int unsigned ASTEROID_WEIGHT = 2,
   parameter int unsigned MAX_ADD         = 7,
   parameter int unsigned ISSUE_GAP       = 2,
   parameter int unsigned PENDING_WIDTH   = 3
) (
   input logic          clk,
   input logic          resetN,
   score_event_if.slave ev
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      GAP
   } state_t;

   localparam logic [PENDING_WIDTH-1:0] CNT_MAX = '1;

   state_t                        state_q, state_d;
   logic [2:0][PENDING_WIDTH-1:0] cnt_q, cnt_d;
   logic [1:0]                    ptr_q, ptr_d;
   logic [5:0]                    rem_q, rem_d;
   logic [3:0]                    gap_q, gap_d;
   logic [2:0]                    add_q, add_d;
   logic                          ovf_q, ovf_d;

   logic [2:0] pulse;
   logic [2:0] nz;
   logic [2:0] grant;
   logic [1:0] idx0, idx1, idx2;
   logic [1:0] gidx;
   logic       gvalid;
   logic [5:0] value;

   function automatic logic [2:0] weight(input logic [1:0] s);
      unique case (s)
         2'd0:    weight = 3'(MONSTER_WEIGHT);
         2'd1:    weight = 3'(BOSS_WEIGHT);
         default: weight = 3'(ASTEROID_WEIGHT);
      endcase
   endfunction

   function automatic logic [2:0] chunk(input logic [5:0] r);
      if (r > 6'(MAX_ADD)) chunk = 3'(MAX_ADD);
      else                  chunk = r[2:0];
   endfunction

   assign pulse = {ev.asteroid_exploded_pulse,
                   ev.boss_died_pulse,
                   ev.monster_died_pulse};

   always_comb begin
      for (int i = 0; i < 3; i++) nz[i] = (cnt_q[i] != '0);
   end

   // Search order starts at the pointer and wraps through the 3 sources.
   always_comb begin
      idx0   = ptr_q;
      idx1   = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
      idx2   = (ptr_q == 2'd0) ? 2'd2 : ptr_q - 2'd1;
      gidx   = idx2;
      if (nz[idx0])      gidx = idx0;
      else if (nz[idx1]) gidx = idx1;
      gvalid = (state_q == IDLE) && (|nz) && !ev.game_over;
      grant  = gvalid ? (3'b001 << gidx) : 3'b000;
      value  = 6'(weight(gidx)) * 6'(ev.stage_num);
   end

   always_comb begin
      ovf_d = ovf_q;
      cnt_d = cnt_q;
      for (int i = 0; i < 3; i++) begin
         if (ev.game_over) begin
            cnt_d[i] = '0;
         end else if (pulse[i] && !grant[i]) begin
            if (cnt_q[i] == CNT_MAX) ovf_d = 1'b1;
            else                     cnt_d[i] = cnt_q[i] + 1'b1;
         end else if (grant[i] && !pulse[i]) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
         end
      end
   end

   // rem_q holds what is left after the chunk currently on add_amount.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      gap_d   = gap_q;
      add_d   = '0;
      ptr_d   = ptr_q;
      if (ev.game_over) begin
         state_d = IDLE;
         rem_d   = '0;
         gap_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (gvalid) begin
                  ptr_d = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
                  if (value != '0) begin
                     add_d   = chunk(value);
                     rem_d   = value - 6'(chunk(value));
                     state_d = ISSUE;
                  end
               end
            end
            ISSUE: begin
               gap_d   = 4'(ISSUE_GAP - 1);
               state_d = GAP;
            end
            GAP: begin
               if (gap_q != '0) begin
                  gap_d = gap_q - 4'd1;
               end else if (rem_q != '0) begin
                  add_d   = chunk(rem_q);
                  rem_d   = rem_q - 6'(chunk(rem_q));
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         rem_q   <= '0;
         gap_q   <= '0;
         add_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         gap_q   <= gap_d;
         add_q   <= add_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ev.add_amount = add_q;
   assign ev.busy       = (state_q != IDLE) || (|nz);
   assign ev.overflow   = ovf_q;

endmodule

// File: tb/tb_score_event_scheduler.sv
// Scoreboard bench for score_event_scheduler: expected chunks are queued
// with their cycle and popped by a monitor whenever add_amount is nonzero.
module tb_score_event_scheduler;

   typedef struct {
      int cyc;
      int amt;
   } exp_t;

   logic clk = 1'b0;
   logic resetN;
   int   chk = 0;
   int   err = 0;
   int   cyc = 0;
   int   t0;
   exp_t sb[$];

   always #5 clk = ~clk;

   score_event_if ev();

   score_event_scheduler dut (
      .clk    (clk),
      .resetN (resetN),
      .ev     (ev)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : mon
      exp_t e;
      if (resetN === 1'b1 && ev.add_amount != 3'd0) begin
         chk++;
         if (sb.size() == 0) begin
            err++;
            $display("FAIL unexpected_add cyc=%0d got=%0d want=none",
                     cyc, ev.add_amount);
         end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || e.amt != int'(ev.add_amount)) begin
               err++;
               $display("FAIL add got=%0d@%0d want=%0d@%0d",
                        ev.add_amount, cyc, e.amt, e.cyc);
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      chk++;
      if (got != want) begin
         err++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
      end
   endtask

   task automatic sb_empty(input string name);
      chk++;
      if (sb.size() != 0) begin
         err++;
         $display("FAIL %s missing_adds got=0 want=%0d", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic push(input int c, input int a);
      sb.push_back('{cyc: c, amt: a});
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic idle_inputs();
      ev.monster_died_pulse      = 1'b0;
      ev.boss_died_pulse         = 1'b0;
      ev.asteroid_exploded_pulse = 1'b0;
      ev.game_over               = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetN = 1'b0;
      idle_inputs();
      @(negedge clk);
      check("rst_add", int'(ev.add_amount), 0);
      check("rst_busy", int'(ev.busy), 0);
      check("rst_ovf", int'(ev.overflow), 0);
      resetN = 1'b1;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      resetN       = 1'b0;
      ev.stage_num = 3'd1;
      idle_inputs();

      // 1: single monster, stage 1
      do_reset();
      ev.stage_num = 3'd1;
      t0 = cyc;
      ev.monster_died_pulse = 1'b1;
      push(t0 + 2, 1);
      @(negedge clk);
      ev.monster_died_pulse = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         wait_to(t0 + k);
         check("t1_busy", int'(ev.busy), (k <= 4) ? 1 : 0);
      end
      wait_to(t0 + 10);
      sb_empty("t1_drain");

      // 2: boss at stage 3 -> 15 split as 7,7,1
      do_reset();
      ev.stage_num = 3'd3;
      t0 = cyc;
      ev.boss_died_pulse = 1'b1;
      push(t0 + 2, 7);
      push(t0 + 5, 7);
      push(t0 + 8, 1);
      @(negedge clk);
      ev.boss_died_pulse = 1'b0;
      wait_to(t0 + 14);
      check("t2_busy_end", int'(ev.busy), 0);
      sb_empty("t2_drain");

      // 3: all three together, round-robin from pointer 0
      do_reset();
      ev.stage_num = 3'd1;
      t0 = cyc;
      ev.monster_died_pulse      = 1'b1;
      ev.boss_died_pulse         = 1'b1;
      ev.asteroid_exploded_pulse = 1'b1;
      push(t0 + 2, 1);
      push(t0 + 6, 5);
      push(t0 + 10, 2);
      @(negedge clk);
      idle_inputs();
      wait_to(t0 + 15);
      check("t3_busy_end", int'(ev.busy), 0);
      sb_empty("t3_drain");

      // 4: saturation of the monster counter
      do_reset();
      ev.stage_num = 3'd1;
      t0 = cyc;
      for (int k = 0; k < 10; k++) push(t0 + 2 + 4 * k, 1);
      for (int k = 0; k < 12; k++) begin
         wait_to(t0 + k);
         ev.monster_died_pulse = 1'b1;
         if (k == 10) check("t4_ovf_pre", int'(ev.overflow), 0);
         if (k == 11) check("t4_ovf_set", int'(ev.overflow), 1);
      end
      wait_to(t0 + 12);
      ev.monster_died_pulse = 1'b0;
      wait_to(t0 + 46);
      check("t4_ovf_hold", int'(ev.overflow), 1);
      check("t4_busy_end", int'(ev.busy), 0);
      sb_empty("t4_drain");

      // 5: game_over mid-event
      do_reset();
      ev.stage_num = 3'd3;
      t0 = cyc;
      ev.boss_died_pulse = 1'b1;
      push(t0 + 2, 7);
      @(negedge clk);
      ev.boss_died_pulse = 1'b0;
      wait_to(t0 + 3);
      ev.game_over          = 1'b1;
      ev.monster_died_pulse = 1'b1;
      wait_to(t0 + 4);
      check("t5_busy_go", int'(ev.busy), 0);
      wait_to(t0 + 5);
      ev.monster_died_pulse = 1'b0;
      check("t5_busy_ign", int'(ev.busy), 0);
      wait_to(t0 + 6);
      ev.game_over = 1'b0;
      wait_to(t0 + 16);
      check("t5_busy_end", int'(ev.busy), 0);
      sb_empty("t5_drain");

      // 6a: stage 0 gives zero value, consumed silently
      do_reset();
      ev.stage_num = 3'd0;
      t0 = cyc;
      ev.asteroid_exploded_pulse = 1'b1;
      @(negedge clk);
      ev.asteroid_exploded_pulse = 1'b0;
      check("t6_busy_c1", int'(ev.busy), 1);
      wait_to(t0 + 2);
      check("t6_busy_c2", int'(ev.busy), 0);
      wait_to(t0 + 10);
      sb_empty("t6_drain");

      // 6b: asynchronous reset during GAP
      do_reset();
      ev.stage_num = 3'd3;
      t0 = cyc;
      ev.boss_died_pulse = 1'b1;
      push(t0 + 2, 7);
      @(negedge clk);
      ev.boss_died_pulse = 1'b0;
      wait_to(t0 + 3);
      check("t6r_busy_gap", int'(ev.busy), 1);
      resetN = 1'b0;
      #1;
      check("t6r_add", int'(ev.add_amount), 0);
      check("t6r_busy", int'(ev.busy), 0);
      check("t6r_ovf", int'(ev.overflow), 0);
      wait_to(t0 + 5);
      resetN = 1'b1;
      wait_to(t0 + 20);
      check("t6r_busy_end", int'(ev.busy), 0);
      sb_empty("t6r_drain");

      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule
